serial_byte_tx: RTL and testbench
=================================

// Module: serial_byte_tx
// PURPOSE
//   Parallel-to-serial transmitter: accepts a DATA_W-bit word on a valid/ready handshake
//   and drives it LSB-first onto a single-wire serial line, framed by start and stop bits.
//   It is the transmit end of the single-wire byte link; the existing receiver samples the
//   line at the same DIV clocks-per-bit rate. It sits between a bus-side producer and the pad.
// PARAMETERS
//   DATA_W   8   payload bits per frame (1..16)
//   DIV      4   clock cycles per serial bit (>= 1; DIV=1 legal)
// PORTS
//   clk       input   1        rising-edge clock
//   rst       input   1        asynchronous reset, active-high
//   data_in   input   DATA_W   word to send; sampled only on acceptance
//   valid     input   1        producer has a word
//   ready     output  1        transmitter can accept a word this cycle
//   tx        output  1        serial line, idles high
//   busy      output  1        frame in progress (any state other than IDLE)
// BEHAVIOUR
//   - Reset (async, rst=1): state=IDLE, tx=1, ready=1, busy=0, shift reg and counters cleared.
//     Reset mid-frame aborts the frame immediately; tx returns high with no glitch low.
//   - Acceptance: valid && ready at a rising edge. data_in is latched into the shift register.
//     ready is high only in IDLE, so it is 0 in the cycle after acceptance.
//   - State machine: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//     IDLE:   tx=1. On acceptance, go to START.
//     START:  tx=0 for DIV cycles.
//     DATA:   tx=shift[0] for DIV cycles per bit, then shift right; DATA_W bits sent LSB first.
//     PARITY: present only with the macro (see CONFIGURATION); DIV cycles.
//     STOP:   tx=1 for DIV cycles, then go to IDLE.
//   - Timing:
//     * First start-bit cycle is the cycle after acceptance.
//     * Frame = (DATA_W+2)*DIV cycles, or (DATA_W+3)*DIV with parity.
//     * ready reasserts in the cycle after the last STOP cycle. Back-to-back frames therefore
//       have exactly one IDLE cycle (tx=1) between the STOP bit and the next START bit.
//   - Bit timing counter: width $clog2(DIV) (min 1). Counts 0..DIV-1 and wraps on each bit
//     boundary. Bit index counter counts 0..DATA_W-1.
//   - data_in and valid changes during a frame are ignored. valid may be held high
//     indefinitely; a word is taken once per IDLE cycle only.
//   - tx and ready are driven straight from registers; no combinational path from valid.
// CONFIGURATION
//   SERIAL_PARITY_EN defined:
//     PARITY state inserted after DATA; tx = even parity (XOR of all DATA_W latched bits)
//     for DIV cycles. Frame length becomes (DATA_W+3)*DIV.
//   SERIAL_PARITY_EN undefined:
//     No PARITY state and no parity logic; DATA goes directly to STOP.
// TESTING (DATA_W=8, DIV=4 unless stated)
//   1. Idle: rst pulse, then valid=0 for 50 cycles -> tx=1, ready=1, busy=0 throughout.
//   2. Send 8'hA5, no parity.
//      -> tx holds each of 0,1,0,1,0,0,1,0,1,1 for 4 cycles (40 cycles total).
//      -> ready=0 and busy=1 for those 40 cycles, then ready=1.
//   3. Parity build, send 8'hA5 -> parity bit 0. Send 8'h07 -> parity bit 1.
//      Each frame is 44 cycles.
//   4. Back-to-back: valid held high with 8'h3C then 8'hC3.
//      -> exactly one tx=1 IDLE cycle between frames; both words received intact.
//   5. Reset mid-frame: assert rst during data bit 3 of 8'h00.
//      -> tx=1 and ready=1 immediately. Next send of 8'hFF produces a clean full frame.
//   6. DIV=1: send 8'h81 -> tx = 0,1,0,0,0,0,0,0,1,1 on consecutive cycles; ready low 10 cycles.

Source files
------------

// File: rtl/serial_byte_tx.sv
// Parallel-to-serial transmitter: valid/ready word in, LSB-first framed serial line out.
// Optional even-parity bit after the data bits when SERIAL_PARITY_EN is defined.
module serial_byte_tx #(
    parameter int DATA_W = 8,
    parameter int DIV    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid,
    output logic              ready,
    output logic              tx,
    output logic              busy
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

`ifdef SERIAL_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t            r_state;
    logic [DATA_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_div_cnt;
    logic [BIT_W-1:0]  r_bit_cnt;
    logic              r_tx;
    logic              r_ready;
    logic              r_busy;
    logic [DATA_W-1:0] w_shift_next;
    logic              w_bit_end;
`ifdef SERIAL_PARITY_EN
    logic              r_parity;
`endif

    assign w_shift_next = r_shift >> 1;
    assign w_bit_end    = (r_div_cnt == DIV_LAST);

    assign ready = r_ready;
    assign tx    = r_tx;
    assign busy  = r_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_tx      <= 1'b1;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
`ifdef SERIAL_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_div_cnt <= '0;
                    r_bit_cnt <= '0;
                    if (valid && r_ready) begin
                        r_shift <= data_in;
`ifdef SERIAL_PARITY_EN
                        r_parity <= ^data_in;
`endif
                        r_state <= S_START;
                        r_tx    <= 1'b0;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_div_cnt <= '0;
                        r_state   <= S_DATA;
                        r_tx      <= r_shift[0];
                    end else begin
                        r_div_cnt <= r_div_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_div_cnt <= '0;
                        if (r_bit_cnt == BIT_LAST) begin
`ifdef SERIAL_PARITY_EN
                            r_state <= S_PARITY;
                            r_tx    <= r_parity;
`else
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
`endif
                        end else begin
                            // tx loads the next bit in the same edge the shift happens
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            r_shift   <= w_shift_next;
                            r_tx      <= w_shift_next[0];
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + 1'b1;
                    end
                end
`ifdef SERIAL_PARITY_EN
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_div_cnt <= '0;
                        r_state   <= S_STOP;
                        r_tx      <= 1'b1;
                    end else begin
                        r_div_cnt <= r_div_cnt + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (w_bit_end) begin
                        r_div_cnt <= '0;
                        r_state   <= S_IDLE;
                        r_tx      <= 1'b1;
                        r_ready   <= 1'b1;
                        r_busy    <= 1'b0;
                    end else begin
                        r_div_cnt <= r_div_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_div_cnt <= '0;
                    r_tx      <= 1'b1;
                    r_ready   <= 1'b1;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_byte_tx.sv
// Directed bench for serial_byte_tx: a DIV=4 instance and a DIV=1 instance, DATA_W=8.
// Define SERIAL_PARITY_EN for both RTL and bench to exercise the parity build.
module tb_serial_byte_tx;

`ifdef SERIAL_PARITY_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in4 = 8'h00;
    logic       valid4 = 1'b0;
    logic       ready4, tx4, busy4;
    logic [7:0] data_in1 = 8'h00;
    logic       valid1 = 1'b0;
    logic       ready1, tx1, busy1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    serial_byte_tx #(.DATA_W(8), .DIV(4)) u_dut4 (
        .clk(clk), .rst(rst), .data_in(data_in4), .valid(valid4),
        .ready(ready4), .tx(tx4), .busy(busy4)
    );

    serial_byte_tx #(.DATA_W(8), .DIV(1)) u_dut1 (
        .clk(clk), .rst(rst), .data_in(data_in1), .valid(valid1),
        .ready(ready1), .tx(tx1), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Frame bit b: 0 start, 1..8 data LSB first, optional parity, then stop
    function automatic logic exp_bit(input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (EXTRA == 1 && b == 9) return ^d;
        return 1'b1;
    endfunction

    // Called at a negedge; returns at the negedge of the first start-bit cycle
    task automatic accept(input bit sel, input logic [7:0] d);
        int t = 0;
        while (!(sel ? ready1 : ready4) && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("ready_before_send", sel ? ready1 : ready4, 1);
        if (sel) begin data_in1 = d; valid1 = 1'b1; end
        else     begin data_in4 = d; valid4 = 1'b1; end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Checks every cycle of one frame starting at the negedge of its first cycle,
    // then the single IDLE cycle that follows
    task automatic check_frame(input bit sel, input logic [7:0] d);
        int div = sel ? 1 : 4;
        int nbits = 10 + EXTRA;
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < div; c++) begin
                chk($sformatf("tx_%0h_bit%0d", d, b), sel ? tx1 : tx4, exp_bit(d, b));
                chk($sformatf("ready_%0h_bit%0d", d, b), sel ? ready1 : ready4, 0);
                chk($sformatf("busy_%0h_bit%0d", d, b), sel ? busy1 : busy4, 1);
                @(negedge clk);
            end
        end
        chk("post_frame_ready", sel ? ready1 : ready4, 1);
        chk("post_frame_tx", sel ? tx1 : tx4, 1);
        chk("post_frame_busy", sel ? busy1 : busy4, 0);
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] d);
        accept(sel, d);
        if (sel) begin valid1 = 1'b0; data_in1 = ~d; end
        else     begin valid4 = 1'b0; data_in4 = ~d; end
        check_frame(sel, d);
    endtask

    initial begin
        // Reset state, then a quiet idle line
        repeat (3) @(negedge clk);
        chk("rst_tx", tx4, 1);
        chk("rst_ready", ready4, 1);
        chk("rst_busy", busy4, 0);
        chk("rst_tx_div1", tx1, 1);
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("idle_tx", tx4, 1);
            chk("idle_ready", ready4, 1);
            chk("idle_busy", busy4, 0);
        end

        // Single frames, including both parity polarities in the parity build
        send_frame(0, 8'hA5);
        send_frame(0, 8'h07);
        send_frame(0, 8'h00);
        send_frame(0, 8'hFF);

        // Back-to-back with valid held high; data change mid-frame must be ignored
        accept(0, 8'h3C);
        data_in4 = 8'hC3;
        check_frame(0, 8'h3C);
        @(negedge clk);
        check_frame(0, 8'hC3);
        valid4 = 1'b0;
        repeat (2) @(negedge clk);
        chk("b2b_quiet_tx", tx4, 1);
        chk("b2b_quiet_ready", ready4, 1);

        // Reset during data bit 3 of 8'h00
        accept(0, 8'h00);
        valid4 = 1'b0;
        repeat (17) @(negedge clk);
        chk("pre_abort_tx", tx4, 0);
        chk("pre_abort_busy", busy4, 1);
        #2 rst = 1'b1;
        #1;
        chk("abort_tx", tx4, 1);
        chk("abort_ready", ready4, 1);
        chk("abort_busy", busy4, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_frame(0, 8'hFF);

        // DIV=1 instance
        send_frame(1, 8'h81);
        send_frame(1, 8'h5A);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
